// File: rtl/pong_pkg.sv
// Shared pong geometry and the paddle tracker state type, used by the renderer,
// the ball logic and the paddle tracker.
package pong_pkg;

  localparam int SCREEN_H = 480;
  localparam int PADDLE_H = 64;
  localparam int MAX_STEP = 8;
  localparam int Y_W      = 10;

  typedef enum logic [1:0] {
    IDLE,
    MULT,
    STEP
  } paddle_state_t;

endpackage

// File: rtl/shift_add_mult8.sv
// 8-cycle sequential shift-add multiplier: constant multiplicand times 8-bit multiplier,
// LSB first. Only the product divided by 256 is exported, which is what the paddle
// scaling consumes.
module shift_add_mult8 #(
  parameter int MC_W = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [MC_W-1:0] mcand_i,
  input  logic [7:0]      mplier_i,
  output logic [MC_W-1:0] prod_hi_o,
  output logic            done_o
);

  logic [7:0]      cnt_q;
  logic [MC_W+7:0] acc_q;
  logic [2:0]      idx_q;
  logic            run_q;
  logic [MC_W+7:0] partial;

  assign partial = {8'd0, mcand_i} << idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else if (start_i && !run_q) begin
      cnt_q <= mplier_i;
      acc_q <= '0;
      idx_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      if (cnt_q[idx_q]) begin
        acc_q <= acc_q + partial;
      end
      idx_q <= idx_q + 3'd1;
      if (idx_q == 3'd7) begin
        run_q <= 1'b0;
      end
    end
  end

  // High during the last accumulate cycle; the result is settled on the next cycle.
  assign done_o    = run_q && (idx_q == 3'd7);
  assign prod_hi_o = acc_q[MC_W+7:8];

endmodule

// File: rtl/paddle_tracker.sv
// Samples the encoder count on COUNT at each VSYNC rise, scales it into the paddle's
// legal range and slews PADDLE_Y toward it by at most MAX_STEP lines per frame.
module paddle_tracker #(
  parameter int SCREEN_H = pong_pkg::SCREEN_H,
  parameter int PADDLE_H = pong_pkg::PADDLE_H,
  parameter int MAX_STEP = pong_pkg::MAX_STEP,
  parameter int Y_W      = pong_pkg::Y_W
) (
  input  logic           CLOCK,
  input  logic           RESET_N,
  input  logic           VSYNC,
  input  logic [7:0]     COUNT,
  output logic [Y_W-1:0] PADDLE_Y,
  output logic           UPDATE,
  output logic           BUSY
);

  import pong_pkg::*;

  localparam int                    RANGE   = SCREEN_H - PADDLE_H;
  localparam logic [Y_W-1:0]        RANGE_Y = Y_W'(RANGE);
  localparam logic [Y_W-1:0]        MID_Y   = Y_W'(RANGE / 2);
  localparam logic [Y_W-1:0]        STEP_Y  = Y_W'(MAX_STEP);
  localparam logic signed [Y_W:0]   STEP_P  = (Y_W+1)'(MAX_STEP);
  localparam logic signed [Y_W:0]   STEP_N  = -STEP_P;

  paddle_state_t         state_q, state_d;
  logic                  vsync_q;
  logic [Y_W-1:0]        paddle_q, paddle_d;
  logic                  update_q, update_d;
  logic                  busy_q;
  logic                  vs_rise;
  logic                  mult_start;
  logic                  mult_done;
  logic [Y_W-1:0]        target;
  logic signed [Y_W:0]   diff;

  assign vs_rise = VSYNC & ~vsync_q;

  shift_add_mult8 #(
    .MC_W(Y_W)
  ) u_mult (
    .clk      (CLOCK),
    .rst_n    (RESET_N),
    .start_i  (mult_start),
    .mcand_i  (RANGE_Y),
    .mplier_i (COUNT),
    .prod_hi_o(target),
    .done_o   (mult_done)
  );

  assign diff = $signed({1'b0, target}) - $signed({1'b0, paddle_q});

  always_comb begin
    state_d    = state_q;
    mult_start = 1'b0;
    paddle_d   = paddle_q;
    update_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (vs_rise) begin
          mult_start = 1'b1;
          state_d    = MULT;
        end
      end
      MULT: begin
        if (mult_done) begin
          state_d = STEP;
        end
      end
      STEP: begin
        if (diff > STEP_P) begin
          paddle_d = paddle_q + STEP_Y;
        end else if (diff < STEP_N) begin
          paddle_d = paddle_q - STEP_Y;
        end else begin
          paddle_d = target;
        end
        update_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // vsync_q resets high so a VSYNC already high at reset release is not an edge.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      vsync_q  <= 1'b1;
      paddle_q <= MID_Y;
      update_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= VSYNC;
      paddle_q <= paddle_d;
      update_q <= update_d;
      busy_q   <= (state_d != IDLE);
    end
  end

  assign PADDLE_Y = paddle_q;
  assign UPDATE   = update_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_paddle_tracker.sv
// Self-checking bench for paddle_tracker: frame-level reference model of the target
// scaling and per-frame slew, with cycle-exact UPDATE/BUSY timing around each frame.
module tb_paddle_tracker;

  localparam int RANGE = 416;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vsync = 1'b1;
  logic [7:0] count = 8'd0;
  logic [9:0] py;
  logic       upd;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int y_m = 208;

  always #5 clk = ~clk;

  paddle_tracker u_dut (
    .CLOCK   (clk),
    .RESET_N (rst_n),
    .VSYNC   (vsync),
    .COUNT   (count),
    .PADDLE_Y(py),
    .UPDATE  (upd),
    .BUSY    (busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // New paddle position after one frame with COUNT value c.
  function automatic int model_next(input int y, input int c);
    int tgt;
    int d;
    tgt = (c * RANGE) / 256;
    d   = tgt - y;
    if (d > 8)       return y + 8;
    else if (d < -8) return y - 8;
    else             return tgt;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One VSYNC rise with COUNT value c; COUNT switches to c_late two cycles later and an
  // optional second rise lands in cycle k+5. Samples tail cycles after the edge.
  task automatic frame(input int c, input int c_late, input bit glitch, input int tail);
    int y_old;
    int y_new;
    y_old = y_m;
    y_new = model_next(y_m, c);
    vsync = 1'b0;
    tick();
    count = c[7:0];
    vsync = 1'b1;
    for (int n = 1; n <= tail; n++) begin
      tick();
      if (n < 10) begin
        check("upd_busy_phase", int'(upd), 0);
        check("busy_phase", int'(busy), 1);
        check("py_hold", int'(py), y_old);
      end else if (n == 10) begin
        check("upd_pulse", int'(upd), 1);
        check("busy_done", int'(busy), 0);
        check("py_new", int'(py), y_new);
      end else begin
        check("upd_after", int'(upd), 0);
        check("busy_after", int'(busy), 0);
        check("py_after", int'(py), y_new);
      end
      if (n == 1) vsync = 1'b0;
      if (n == 2) count = c_late[7:0];
      if (glitch && n == 5) vsync = 1'b1;
      if (glitch && n == 6) vsync = 1'b0;
    end
    y_m = y_new;
  endtask

  int exp104 [5] = '{200, 192, 184, 176, 169};
  int c_r;

  initial begin
    // Reset with VSYNC held high through release: no update may follow.
    vsync = 1'b1;
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_py", int'(py), 208);
    check("rst_upd", int'(upd), 0);
    check("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_py", int'(py), 208);
      check("idle_upd", int'(upd), 0);
      check("idle_busy", int'(busy), 0);
    end

    for (int i = 0; i < 5; i++) begin
      frame(104, 104, 1'b0, 11);
      check("c104_seq", int'(py), exp104[i]);
    end

    for (int i = 0; i < 35; i++) frame(255, 255, 1'b0, 11);
    check("c255_settle", int'(py), 414);
    for (int i = 0; i < 55; i++) frame(0, 0, 1'b0, 11);
    check("c0_settle", int'(py), 0);

    // Late COUNT change plus a dropped second edge.
    frame(255, 255, 1'b0, 11);
    frame(0, 255, 1'b1, 16);
    check("latched_zero", int'(py), 0);

    // Reset in the middle of MULT.
    frame(200, 200, 1'b0, 11);
    vsync = 1'b0;
    tick();
    count = 8'd255;
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_py", int'(py), 208);
    check("midrst_busy", int'(busy), 0);
    check("midrst_upd", int'(upd), 0);
    y_m = 208;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    frame(255, 255, 1'b0, 11);
    check("post_rst", int'(py), 216);

    // Same COUNT frame after frame: keeps pulsing, position stays put once settled.
    for (int i = 0; i < 30; i++) frame(128, 128, 1'b0, 11);
    check("c128_settle", int'(py), 208);

    for (int i = 0; i < 40; i++) begin
      c_r = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1)
        frame(c_r, int'($urandom_range(0, 255)), 1'b1, 16);
      else
        frame(c_r, int'($urandom_range(0, 255)), 1'b0, 11);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
